// File: rtl/tdes_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tdes_sequencer: steps one shared DES core through the three EDE passes of   |
// | Triple-DES, with valid/ready handshakes on the host side. Revision 1.0      |
// +----------------------------------------------------------------------------+
module tdes_sequencer #(
  parameter int CORE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [1:64] in_text,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] out_text,
  output logic [1:64] des_in,
  output logic        des_dec,
  output logic [1:0]  des_key_sel,
  input  logic [1:64] des_out,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] LAT_RELOAD = 4'(CORE_LAT - 1);

  state_t      state_q, state_d;
  logic [1:64] data_q, data_d;
  logic        mode_q, mode_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      mode_q    <= 1'b0;
      lat_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mode_q    <= mode_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    mode_d      = mode_q;
    lat_cnt_d   = lat_cnt_q;
    des_key_sel = 2'b00;
    des_dec     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d    = in_text;
          mode_d    = in_mode;
          lat_cnt_d = LAT_RELOAD;
          state_d   = S_P1;
        end
      end
      S_P1, S_P2, S_P3: begin
        // Decrypt mode walks the key sets in reverse with each direction flipped.
        case (state_q)
          S_P1:    begin des_key_sel = mode_q ? 2'b11 : 2'b01; des_dec = mode_q;  end
          S_P2:    begin des_key_sel = 2'b10;                  des_dec = ~mode_q; end
          default: begin des_key_sel = mode_q ? 2'b01 : 2'b11; des_dec = mode_q;  end
        endcase
        if (lat_cnt_q != 4'd0) begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end else begin
          data_d    = des_out;
          lat_cnt_d = LAT_RELOAD;
          case (state_q)
            S_P1:    state_d = S_P2;
            S_P2:    state_d = S_P3;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_text  = data_q;
  assign des_in    = data_q;

endmodule
`default_nettype wire

// File: tb/tb_tdes_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tdes_sequencer: drives three sequencers (CORE_LAT 1, 2, 4) against a     |
// | behavioural DES core and a Triple-DES reference. Revision 1.0               |
// +----------------------------------------------------------------------------+
module tb_tdes_sequencer;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int PC1_T [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                                10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  localparam int PC2_T [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                                23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                                41,52,31,37,47,55,30,40,51,45,33,48,
                                44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int P_T [32] = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                               2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
  localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SBOX_T [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  localparam logic [1:64] STD_KEY = 64'h133457799BBCDFF1;
  localparam logic [1:64] STD_PT  = 64'h0123456789ABCDEF;
  localparam logic [1:64] STD_CT  = 64'h85E813540F0AB405;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid    [3];
  logic        in_ready    [3];
  logic        in_mode     [3];
  logic [1:64] in_text     [3];
  logic        out_valid   [3];
  logic        out_ready   [3];
  logic [1:64] out_text    [3];
  logic [1:64] des_in      [3];
  logic        des_dec     [3];
  logic [1:0]  des_key_sel [3];
  logic        busy        [3];

  logic [1:64] key1, key2, key3;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Single-block DES, FIPS 46 tables; bit 1 is the MSB.
  function automatic logic [1:64] des(input logic [1:64] blk, input logic [1:64] key, input bit dec);
    logic [1:56] cd;
    logic [1:28] c, d;
    logic [1:48] ks [16];
    logic [1:48] e;
    logic [1:64] ipb, pre, res;
    logic [1:32] l, r, nr, sout, pf;
    logic [1:6]  six;
    int v, idx, row, col;
    for (int i = 1; i <= 56; i++) cd[i] = key[PC1_T[i-1]];
    c = cd[1:28];
    d = cd[29:56];
    for (int rd = 0; rd < 16; rd++) begin
      for (int s = 0; s < SHIFT_T[rd]; s++) begin
        c = {c[2:28], c[1]};
        d = {d[2:28], d[1]};
      end
      cd = {c, d};
      for (int i = 1; i <= 48; i++) ks[rd][i] = cd[PC2_T[i-1]];
    end
    for (int i = 1; i <= 64; i++) ipb[i] = blk[IP_T[i-1]];
    l = ipb[1:32];
    r = ipb[33:64];
    for (int rd = 0; rd < 16; rd++) begin
      for (int g = 0; g < 8; g++) begin
        for (int k = 0; k < 6; k++) begin
          idx = 4*g + k;
          if (idx == 0) idx = 32;
          else if (idx == 33) idx = 1;
          e[6*g+k+1] = r[idx];
        end
      end
      e = e ^ ks[dec ? 15 - rd : rd];
      for (int s = 0; s < 8; s++) begin
        for (int k = 1; k <= 6; k++) six[k] = e[6*s+k];
        row = int'(six[1])*2 + int'(six[6]);
        col = int'(six[2])*8 + int'(six[3])*4 + int'(six[4])*2 + int'(six[5]);
        v = SBOX_T[s*64 + row*16 + col];
        for (int j = 0; j < 4; j++) sout[4*s+1+j] = v[3-j];
      end
      for (int i = 1; i <= 32; i++) pf[i] = sout[P_T[i-1]];
      nr = l ^ pf;
      l  = r;
      r  = nr;
    end
    pre = {r, l};
    for (int i = 1; i <= 64; i++) res[IP_T[i-1]] = pre[i];
    return res;
  endfunction

  function automatic logic [1:64] tdes_ref(input logic [1:64] t, input bit m);
    if (!m) return des(des(des(t, key1, 1'b0), key2, 1'b1), key3, 1'b0);
    return des(des(des(t, key3, 1'b1), key2, 1'b0), key1, 1'b1);
  endfunction

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : (u == 1) ? 2 : 4;
  endfunction

  // Each core answers with all-ones until the CORE_LAT-th cycle of a pass.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LATV = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [1:64] core_q = '1;
    logic [1:64] kk;
    logic [1:0]  last_sel = 2'b00;
    int          cnt = 0;

    always @(negedge clk) begin
      if (des_key_sel[g] == 2'b00) cnt = 0;
      else if (des_key_sel[g] != last_sel) cnt = 1;
      else cnt = cnt + 1;
      last_sel = des_key_sel[g];
      kk = (des_key_sel[g] == 2'b01) ? key1 : (des_key_sel[g] == 2'b10) ? key2 : key3;
      core_q <= (cnt == LATV) ? des(des_in[g], kk, des_dec[g]) : '1;
    end

    tdes_sequencer #(.CORE_LAT(LATV)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_mode    (in_mode[g]),
      .in_text    (in_text[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_text   (out_text[g]),
      .des_in     (des_in[g]),
      .des_dec    (des_dec[g]),
      .des_key_sel(des_key_sel[g]),
      .des_out    (core_q),
      .busy       (busy[g])
    );
  end

  task automatic check_reset_outputs(input int u, input string pfx);
    check($sformatf("%s_in_ready%0d", pfx, u), in_ready[u], 1);
    check($sformatf("%s_out_valid%0d", pfx, u), out_valid[u], 0);
    check($sformatf("%s_busy%0d", pfx, u), busy[u], 0);
    check($sformatf("%s_out_text%0d", pfx, u), out_text[u], 0);
    check($sformatf("%s_des_in%0d", pfx, u), des_in[u], 0);
    check($sformatf("%s_key_sel%0d", pfx, u), des_key_sel[u], 0);
    check($sformatf("%s_des_dec%0d", pfx, u), des_dec[u], 0);
  endtask

  // Called 1 time unit after a rising edge with the DUT idle; returns once out_valid is seen.
  task automatic do_block(input int u, input logic [1:64] txt, input bit mode,
                          input logic [1:64] exp, input string tag);
    int n, bad, p, lat;
    logic [1:0] es;
    logic ed;
    lat = lat_of(u);
    in_valid[u] = 1'b1;
    in_text[u]  = txt;
    in_mode[u]  = mode;
    check({tag, "_in_ready"}, in_ready[u], 1);
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    in_text[u]  = {$urandom, $urandom};
    in_mode[u]  = ~mode;
    n = 0;
    bad = 0;
    while (!out_valid[u] && n < 100) begin
      p  = n / lat;
      es = 2'(mode ? 3 - p : p + 1);
      ed = mode ? (p != 1) : (p == 1);
      if (p > 2 || des_key_sel[u] != es || des_dec[u] != ed || !busy[u] || in_ready[u]) bad++;
      if (n == 0) check({tag, "_des_in"}, des_in[u], txt);
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_out_valid"}, out_valid[u], 1);
    check({tag, "_latency"}, 64'(n), 64'(3 * lat));
    check({tag, "_pass_seq_bad"}, 64'(bad), 0);
    check({tag, "_out_text"}, out_text[u], exp);
    if (out_ready[u]) begin
      @(posedge clk); #1;
      check({tag, "_back_idle"}, {in_ready[u], out_valid[u]}, 2'b10);
    end
  endtask

  initial begin : main
    logic [1:64] t, x;
    logic [1:64] tp_txt [4];
    logic [1:64] tp_exp [4];
    bit          tp_mode [4];
    int          acc_t [4];
    int          cyc, nacc, nres, seen;
    bit          acc, tk, m;

    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      in_valid[u] = 1'b0;
      in_mode[u] = 1'b0;
      in_text[u] = '0;
      out_ready[u] = 1'b0;
    end
    key1 = STD_KEY;
    key2 = STD_KEY;
    key3 = STD_KEY;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) check_reset_outputs(u, "rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer encrypt and decrypt with all three keys equal.
    out_ready[0] = 1'b1;
    do_block(0, STD_PT, 1'b0, STD_CT, "kat_enc");
    do_block(0, STD_CT, 1'b1, STD_PT, "kat_dec");

    // Backpressure while new blocks are offered.
    key1 = {$urandom, $urandom};
    key2 = {$urandom, $urandom};
    key3 = {$urandom, $urandom};
    out_ready[0] = 1'b0;
    t = {$urandom, $urandom};
    x = tdes_ref(t, 1'b0);
    do_block(0, t, 1'b0, x, "bp");
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = (i % 2 == 0);
      in_text[0]  = {$urandom, $urandom};
      @(posedge clk); #1;
      check($sformatf("bp_hold_valid%0d", i), out_valid[0], 1);
      check($sformatf("bp_hold_text%0d", i), out_text[0], x);
      check($sformatf("bp_hold_ready%0d", i), in_ready[0], 0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", {in_ready[0], busy[0], out_valid[0]}, 3'b100);
    @(posedge clk); #1;
    check("bp_no_accept", busy[0], 0);

    // Latency 4: all-ones garbage on every cycle but the capture cycle.
    key1 = STD_KEY;
    key2 = STD_KEY;
    key3 = STD_KEY;
    out_ready[2] = 1'b1;
    do_block(2, STD_PT, 1'b0, STD_CT, "lat4_kat");
    key1 = {$urandom, $urandom};
    key2 = {$urandom, $urandom};
    key3 = {$urandom, $urandom};
    t = {$urandom, $urandom};
    do_block(2, t, 1'b1, tdes_ref(t, 1'b1), "lat4_dec");

    // Asynchronous reset in the middle of the second pass.
    t = {$urandom, $urandom};
    in_valid[2] = 1'b1;
    in_text[2]  = t;
    in_mode[2]  = 1'b0;
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("mid_reset_in_p2", des_key_sel[2], 2'b10);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(2, "mid_rst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid[2]) seen++;
    end
    check("mid_rst_no_out_valid", 64'(seen), 0);
    t = {$urandom, $urandom};
    do_block(2, t, 1'b0, tdes_ref(t, 1'b0), "post_rst");

    // Back-to-back throughput on the CORE_LAT=2 instance.
    for (int i = 0; i < 4; i++) begin
      tp_txt[i]  = {$urandom, $urandom};
      tp_mode[i] = 1'($urandom);
      tp_exp[i]  = tdes_ref(tp_txt[i], tp_mode[i]);
    end
    in_valid[1]  = 1'b1;
    in_text[1]   = tp_txt[0];
    in_mode[1]   = tp_mode[0];
    out_ready[1] = 1'b1;
    cyc = 0;
    nacc = 0;
    nres = 0;
    while (nres < 4 && cyc < 200) begin
      acc = in_valid[1] && in_ready[1];
      tk  = out_valid[1] && out_ready[1];
      if (tk) begin
        check($sformatf("tp_result%0d", nres), out_text[1], tp_exp[nres]);
        nres++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        acc_t[nacc] = cyc;
        nacc++;
        if (nacc < 4) begin
          in_text[1] = tp_txt[nacc];
          in_mode[1] = tp_mode[nacc];
        end else begin
          in_valid[1] = 1'b0;
        end
      end
    end
    check("tp_all_results", 64'(nres), 4);
    for (int i = 1; i < 4; i++)
      check($sformatf("tp_period%0d", i), 64'(acc_t[i] - acc_t[i-1]), 8);
    @(posedge clk); #1;

    // Randomized blocks on every instance.
    for (int u = 0; u < 3; u++) begin
      out_ready[u] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        key1 = {$urandom, $urandom};
        key2 = {$urandom, $urandom};
        key3 = {$urandom, $urandom};
        t = {$urandom, $urandom};
        m = 1'($urandom);
        do_block(u, t, m, tdes_ref(t, m), $sformatf("rnd_u%0d_%0d", u, i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
